// File: rtl/elbeth_pkg.sv
`default_nettype none
// ============================================================================
// Module : elbeth_pkg
// Shared encodings for the elbeth memory arbiter: FSM states, owner ids,
// and default bus widths.
// Rev    : 1.0
// ============================================================================
package elbeth_pkg;

  localparam int C_ADDR_W_DEF = 8;
  localparam int C_DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/elbeth_arb_pick.sv
`default_nettype none
// ============================================================================
// Module : elbeth_arb_pick
// Combinational 2-way picker: fixed data priority or round-robin.
// Rev    : 1.0
// ============================================================================
module elbeth_arb_pick
  import elbeth_pkg::*;
#(
  parameter int DATA_PRIO = 0
) (
  input  logic   req_i,
  input  logic   req_d,
  input  owner_t last_grant,
  output logic   grant_d
);

  always_comb begin
    grant_d = 1'b0;
    if (req_d && !req_i) begin
      grant_d = 1'b1;
    end else if (req_d && req_i) begin
      // Under round-robin, the port that did not win last time goes now.
      grant_d = (DATA_PRIO != 0) ? 1'b1 : (last_grant == OWN_I);
    end
  end

endmodule
`default_nettype wire

// File: rtl/elbeth_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : elbeth_mem_arbiter
// Shares one single-port memory between the instruction and data ports,
// one captured request at a time, with a watchdog abort.
// Rev    : 1.0
// ============================================================================
module elbeth_mem_arbiter
  import elbeth_pkg::*;
#(
  parameter int ADDR_W    = C_ADDR_W_DEF,
  parameter int DATA_W    = C_DATA_W_DEF,
  parameter int DATA_PRIO = 0,
  parameter int TIMEOUT   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                imem_en,
  input  logic [ADDR_W-1:0]   imem_addr,
  input  logic [DATA_W-1:0]   imem_wdata,
  input  logic [DATA_W/8-1:0] imem_rw,
  output logic [DATA_W-1:0]   imem_rdata,
  output logic                imem_ready,
  output logic                imem_error,
  input  logic                dmem_en,
  input  logic [ADDR_W-1:0]   dmem_addr,
  input  logic [DATA_W-1:0]   dmem_wdata,
  input  logic [DATA_W/8-1:0] dmem_rw,
  output logic [DATA_W-1:0]   dmem_rdata,
  output logic                dmem_ready,
  output logic                dmem_error,
  output logic                m_en,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_rw,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready
);

  localparam int              C_WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [C_WD_W-1:0] C_WD_LAST = C_WD_W'(TIMEOUT - 1);

  state_t                state_q;
  owner_t                owner_q;
  owner_t                last_q;
  logic [C_WD_W-1:0]     wdog_q;
  logic                  m_en_q;
  logic [ADDR_W-1:0]     m_addr_q;
  logic [DATA_W-1:0]     m_wdata_q;
  logic [DATA_W/8-1:0]   m_rw_q;
  logic [DATA_W-1:0]     i_rdata_q;
  logic [DATA_W-1:0]     d_rdata_q;
  logic                  i_ready_q;
  logic                  d_ready_q;
  logic                  i_error_q;
  logic                  d_error_q;
  logic                  grant_d;

  elbeth_arb_pick #(
    .DATA_PRIO (DATA_PRIO)
  ) u_pick (
    .req_i      (imem_en),
    .req_d      (dmem_en),
    .last_grant (last_q),
    .grant_d    (grant_d)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_I;
      last_q    <= OWN_I;
      wdog_q    <= '0;
      m_en_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_rw_q    <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_error_q <= 1'b0;
      d_error_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (imem_en || dmem_en) begin
            if (grant_d) begin
              m_addr_q  <= dmem_addr;
              m_wdata_q <= dmem_wdata;
              m_rw_q    <= dmem_rw;
              owner_q   <= OWN_D;
              last_q    <= OWN_D;
            end else begin
              m_addr_q  <= imem_addr;
              m_wdata_q <= imem_wdata;
              m_rw_q    <= imem_rw;
              owner_q   <= OWN_I;
              last_q    <= OWN_I;
            end
            m_en_q  <= 1'b1;
            wdog_q  <= '0;
            state_q <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          wdog_q <= wdog_q + C_WD_W'(1);
          // A real completion on the last watchdog cycle takes precedence.
          if (m_ready) begin
            m_en_q <= 1'b0;
            if (owner_q == OWN_D) begin
              d_rdata_q <= m_rdata;
              d_ready_q <= 1'b1;
            end else begin
              i_rdata_q <= m_rdata;
              i_ready_q <= 1'b1;
            end
            state_q <= ST_DONE;
          end else if (wdog_q == C_WD_LAST) begin
            m_en_q <= 1'b0;
            if (owner_q == OWN_D) begin
              d_rdata_q <= '0;
              d_ready_q <= 1'b1;
              d_error_q <= 1'b1;
            end else begin
              i_rdata_q <= '0;
              i_ready_q <= 1'b1;
              i_error_q <= 1'b1;
            end
            state_q <= ST_DONE;
          end
        end

        ST_DONE: begin
          i_ready_q <= 1'b0;
          d_ready_q <= 1'b0;
          i_error_q <= 1'b0;
          d_error_q <= 1'b0;
          state_q   <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_en       = m_en_q;
  assign m_addr     = m_addr_q;
  assign m_wdata    = m_wdata_q;
  assign m_rw       = m_rw_q;
  assign imem_rdata = i_rdata_q;
  assign imem_ready = i_ready_q;
  assign imem_error = i_error_q;
  assign dmem_rdata = d_rdata_q;
  assign dmem_ready = d_ready_q;
  assign dmem_error = d_error_q;

endmodule
`default_nettype wire
